mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter sitting directly upstream of the main memory. It merges the instruction-cache and data-cache line requests (type_cache2mem_s) onto the single cache-to-memory interface, and routes the memory response (type_mem2cache_s) back to the granted cache.
- One 128-bit line transaction is outstanding at a time.
- A timeout watchdog flags a memory that never acknowledges.

Parameters:
- ARB_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, dcache wins.
- TIMEOUT_CYCLES, 255, cycles in BUSY without mem ack before timeout_o asserts; range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- icache2mem_i  input  type_cache2mem_s  icache request (req, w_en, addr, w_data[127:0]).
- mem2icache_o  output  type_mem2cache_s  response to icache (ack, r_data[127:0]).
- dcache2mem_i  input  type_cache2mem_s  dcache request.
- mem2dcache_o  output  type_mem2cache_s  response to dcache.
- arb2mem_o  output  type_cache2mem_s  request to main memory (registered).
- mem2arb_i  input  type_mem2cache_s  response from main memory.
- timeout_o  output  1  sticky watchdog flag.

Behaviour:
- Reset values:
  - arb2mem_o = '0; mem2icache_o = '0; mem2dcache_o = '0; timeout_o = 0.
  - state = IDLE; last_grant = ICACHE; wd_cnt = 0.
- States and transitions:
  - IDLE: if any req, select a winner, latch its full request into arb2mem_o with req=1, set grant, go to BUSY. No req: stay.
  - BUSY: hold arb2mem_o stable. On mem2arb_i.ack: clear arb2mem_o.req (and the whole struct) at the same edge, set last_grant = grant, go to DONE.
  - DONE: one cycle, no grant, absorbs the requester's registered req drop. Then go to IDLE.
- Arbitration:
  - ARB_MODE=0: if both ports request, grant the port that is not last_grant. After reset, dcache wins first.
  - ARB_MODE=1: dcache always wins ties.
  - A single requester always wins.
- Response routing:
  - Combinational. In BUSY, the granted port's response = mem2arb_i (ack and r_data pass through). The other port sees '0.
  - Outside BUSY, both responses are '0. A stray mem ack (e.g. after reset mid-transaction) is dropped.
- Requester rule: hold req and the struct stable until ack is seen; req must be low no later than the cycle after DONE. Req still high in IDLE is a new request.
- Latency: req sampled in IDLE at edge N; arb2mem_o.req high after edge N; earliest ack forwarded in cycle N+1 (memory-dependent); DONE at N+2; IDLE at N+3.
- Writes: w_en and w_data are forwarded unchanged. The ack is forwarded; r_data is a don't-care for writes.
- Watchdog:
  - wd_cnt clears on entering BUSY and increments each BUSY cycle without ack, saturating at TIMEOUT_CYCLES.
  - When wd_cnt reaches TIMEOUT_CYCLES, timeout_o is set and stays set until rst.
  - The transaction is not aborted.
- Simultaneous events:
  - Mem ack in the same cycle as a new request from the other port: the other port is handled after DONE.
  - Request inputs changing while BUSY are ignored.
- Async rst mid-BUSY: outputs go to '0 immediately; the memory's pending ack is then ignored in IDLE.

Decomposition:
- Add to cache_defs.svh:
  - typedef enum type_mem_arb_states_e {MEM_ARB_IDLE, MEM_ARB_BUSY, MEM_ARB_DONE}.
  - typedef enum type_mem_arb_port_e {ARB_ICACHE, ARB_DCACHE}.
- Sub-module mem_arb_sel: combinational 2-way winner select from (req vector, last_grant, ARB_MODE).
- FSM, latch, routing and watchdog stay in mem_arbiter.

Test Plan:
- Icache read only, addr=0x80000010, memory ack after 2 cycles with r_data=128'hA5…: arb2mem_o.addr=0x80000010, w_en=0; mem2icache_o.ack pulses one cycle with the same r_data; mem2dcache_o stays '0.
- Both ports request in the same cycle after reset, ARB_MODE=0: dcache served first, icache second. Repeat: the grant alternates dcache then icache.
- ARB_MODE=1, both ports continuously requesting: dcache granted each time; icache starves, no grant.
- Dcache write, w_data=128'h0123…CDEF, addr=0x40: arb2mem_o.w_en=1 with an exact data match. Ack forwarded to dcache only. Exactly one DONE cycle, then IDLE.
- Memory never acks, TIMEOUT_CYCLES=8: timeout_o rises after 8 BUSY cycles and stays high. A later ack still completes the transaction normally.
- rst pulsed in BUSY, then memory ack arrives: all outputs '0 during reset. The ack is not forwarded to either cache; state is IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared cache/memory interface types and arbiter enums
package mem_arbiter_pkg;
  typedef struct packed {
    logic         req;
    logic         w_en;
    logic [31:0]  addr;
    logic [127:0] w_data;
  } type_cache2mem_s;
  typedef struct packed {
    logic         ack;
    logic [127:0] r_data;
  } type_mem2cache_s;
  typedef enum logic [1:0] {MEM_ARB_IDLE, MEM_ARB_BUSY, MEM_ARB_DONE} type_mem_arb_states_e;
  typedef enum logic {ARB_ICACHE, ARB_DCACHE} type_mem_arb_port_e;
endpackage

// File: rtl/mem_arb_sel.sv
// mem_arb_sel: two-way winner select, round-robin or dcache-priority on ties
module mem_arb_sel
  import mem_arbiter_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic [1:0]         req,
  input  type_mem_arb_port_e last_grant,
  output type_mem_arb_port_e winner
);
  assign winner = (req == 2'b11)
                ? ((ARB_MODE == 1 || last_grant == ARB_ICACHE) ? ARB_DCACHE : ARB_ICACHE)
                : (req[1] ? ARB_DCACHE : ARB_ICACHE);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges icache/dcache line requests onto one memory port, one transaction at a time
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  type_cache2mem_s icache2mem_i,
  output type_mem2cache_s mem2icache_o,
  input  type_cache2mem_s dcache2mem_i,
  output type_mem2cache_s mem2dcache_o,
  output type_cache2mem_s arb2mem_o,
  input  type_mem2cache_s mem2arb_i,
  output logic            timeout_o
);
  localparam logic [7:0] WD_MAX = 8'(TIMEOUT_CYCLES);
  type_mem_arb_states_e state, state_next;
  type_mem_arb_port_e   grant, last_grant, winner;
  logic [7:0]           wd_cnt;
  logic                 any_req;
  mem_arb_sel #(.ARB_MODE(ARB_MODE)) u_sel (
    .req        ({dcache2mem_i.req, icache2mem_i.req}),
    .last_grant (last_grant),
    .winner     (winner)
  );
  // Responses only pass through while a transaction is live; stray acks are dropped.
  always_comb begin
    any_req      = icache2mem_i.req | dcache2mem_i.req;
    state_next   = (state == MEM_ARB_IDLE) ? (any_req ? MEM_ARB_BUSY : MEM_ARB_IDLE)
                 : (state == MEM_ARB_BUSY) ? (mem2arb_i.ack ? MEM_ARB_DONE : MEM_ARB_BUSY)
                 : MEM_ARB_IDLE;
    mem2icache_o = (state == MEM_ARB_BUSY && grant == ARB_ICACHE) ? mem2arb_i : type_mem2cache_s'('0);
    mem2dcache_o = (state == MEM_ARB_BUSY && grant == ARB_DCACHE) ? mem2arb_i : type_mem2cache_s'('0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MEM_ARB_IDLE;
      grant      <= ARB_ICACHE;
      last_grant <= ARB_ICACHE;
      arb2mem_o  <= '0;
      wd_cnt     <= '0;
      timeout_o  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == MEM_ARB_IDLE && any_req) begin
        grant     <= winner;
        arb2mem_o <= (winner == ARB_DCACHE) ? dcache2mem_i : icache2mem_i;
        wd_cnt    <= '0;
      end
      if (state == MEM_ARB_BUSY) begin
        if (mem2arb_i.ack) begin
          arb2mem_o  <= '0;
          last_grant <= grant;
        end else if (wd_cnt != WD_MAX) begin
          wd_cnt <= wd_cnt + 8'd1;
        end
        if (!mem2arb_i.ack && wd_cnt == WD_MAX - 8'd1)
          timeout_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus on round-robin and dcache-priority arbiters,
// compared every cycle against a transaction-level model plus literal expectations
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  type_cache2mem_s ic, dc, am0, am1;
  type_mem2cache_s mem, ir0, dr0, ir1, dr1;
  logic to0, to1;
  int checks = 0;
  int errors = 0;
  bit m_busy[2], m_done[2], m_to[2];
  int m_gnt[2], m_last[2], m_cnt[2];
  type_cache2mem_s m_req[2];

  always #5 clk = ~clk;

  mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(TO)) dut0 (
    .clk(clk), .rst(rst), .icache2mem_i(ic), .mem2icache_o(ir0), .dcache2mem_i(dc),
    .mem2dcache_o(dr0), .arb2mem_o(am0), .mem2arb_i(mem), .timeout_o(to0));
  mem_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(TO)) dut1 (
    .clk(clk), .rst(rst), .icache2mem_i(ic), .mem2icache_o(ir1), .dcache2mem_i(dc),
    .mem2dcache_o(dr1), .arb2mem_o(am1), .mem2arb_i(mem), .timeout_o(to1));

  task automatic chk(string n, logic [161:0] act, logic [161:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Model index 0 is round-robin, index 1 is dcache-priority; 0 = icache, 1 = dcache.
  function automatic int win(int d);
    return (ic.req && dc.req) ? ((d == 1) ? 1 : 1 - m_last[d]) : (dc.req ? 1 : 0);
  endfunction

  always @(posedge clk or posedge rst)
    for (int d = 0; d < 2; d++)
      if (rst) begin
        m_busy[d] <= 1'b0;
        m_done[d] <= 1'b0;
        m_to[d]   <= 1'b0;
        m_gnt[d]  <= 0;
        m_last[d] <= 0;
        m_cnt[d]  <= 0;
        m_req[d]  <= '0;
      end else if (m_done[d]) begin
        m_done[d] <= 1'b0;
      end else if (m_busy[d] && mem.ack) begin
        m_busy[d] <= 1'b0;
        m_done[d] <= 1'b1;
        m_last[d] <= m_gnt[d];
        m_req[d]  <= '0;
      end else if (m_busy[d]) begin
        m_cnt[d] <= (m_cnt[d] < TO) ? m_cnt[d] + 1 : TO;
        if (m_cnt[d] + 1 >= TO) m_to[d] <= 1'b1;
      end else if (ic.req || dc.req) begin
        m_gnt[d]  <= win(d);
        m_req[d]  <= (win(d) == 1) ? dc : ic;
        m_busy[d] <= 1'b1;
        m_cnt[d]  <= 0;
      end

  task automatic cmp(int d, type_cache2mem_s a, type_mem2cache_s i, type_mem2cache_s r, logic t);
    type_mem2cache_s z = '0;
    chk($sformatf("arb2mem_%0d", d), a, m_req[d]);
    chk($sformatf("mem2icache_%0d", d), i, (m_busy[d] && m_gnt[d] == 0) ? mem : z);
    chk($sformatf("mem2dcache_%0d", d), r, (m_busy[d] && m_gnt[d] == 1) ? mem : z);
    chk($sformatf("timeout_%0d", d), t, m_to[d]);
  endtask

  always @(negedge clk) begin
    cmp(0, am0, ir0, dr0, to0);
    cmp(1, am1, ir1, dr1, to1);
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sample the request, wait n BUSY cycles, ack in the n-th, then DONE and back to IDLE.
  task automatic serve(int n, logic [127:0] rd, int p0, int p1, bit drop, type_cache2mem_s exp0);
    tick(n);
    chk("req_latched_0", am0, exp0);
    mem = '{ack: 1'b1, r_data: rd};
    #3;
    chk("ack_grant_0", p0 ? dr0.ack : ir0.ack, 1'b1);
    chk("ack_other_0", p0 ? ir0.ack : dr0.ack, 1'b0);
    chk("data_grant_0", p0 ? dr0.r_data : ir0.r_data, rd);
    chk("ack_grant_1", p1 ? dr1.ack : ir1.ack, 1'b1);
    chk("ack_other_1", p1 ? ir1.ack : dr1.ack, 1'b0);
    tick(1);
    mem = '0;
    if (drop) begin
      ic = '0;
      dc = '0;
    end
    #3 chk("req_cleared_0", am0.req, 1'b0);
    tick(1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    ic = '0;
    dc = '0;
    mem = '0;
    #1 rst = 1'b1;
    #2 chk("reset_arb", am0, '0);
    chk("reset_timeout", to0, 1'b0);
    tick(2);
    rst = 1'b0;
    // icache read, ack in the second BUSY cycle
    ic = '{req: 1'b1, w_en: 1'b0, addr: 32'h8000_0010, w_data: '0};
    serve(2, {16{8'hA5}}, 0, 0, 1, '{req: 1'b1, w_en: 1'b0, addr: 32'h8000_0010, w_data: '0});
    chk("t1_dcache_quiet", dr0, '0);
    // both ports requesting continuously: round-robin alternates, priority starves icache
    pulse_rst();
    ic = '{req: 1'b1, w_en: 1'b0, addr: 32'h100, w_data: '0};
    dc = '{req: 1'b1, w_en: 1'b0, addr: 32'h200, w_data: '0};
    serve(1, 128'h11, 1, 1, 0, '{req: 1'b1, w_en: 1'b0, addr: 32'h200, w_data: '0});
    serve(1, 128'h22, 0, 1, 0, '{req: 1'b1, w_en: 1'b0, addr: 32'h100, w_data: '0});
    serve(2, 128'h33, 1, 1, 0, '{req: 1'b1, w_en: 1'b0, addr: 32'h200, w_data: '0});
    serve(1, 128'h44, 0, 1, 1, '{req: 1'b1, w_en: 1'b0, addr: 32'h100, w_data: '0});
    // dcache write forwarded unchanged, then a follow-on icache request after one DONE cycle
    dc = '{req: 1'b1, w_en: 1'b1, addr: 32'h40, w_data: 128'h0123456789ABCDEF0123456789ABCDEF};
    serve(3, 128'h0, 1, 1, 1,
          '{req: 1'b1, w_en: 1'b1, addr: 32'h40, w_data: 128'h0123456789ABCDEF0123456789ABCDEF});
    ic = '{req: 1'b1, w_en: 1'b0, addr: 32'h300, w_data: '0};
    tick(1);
    chk("t4_next_grant", am0.req, 1'b1);
    // memory silent: timeout after 8 BUSY cycles, sticky, late ack still completes
    tick(7);
    chk("t5_before_to", to0, 1'b0);
    tick(1);
    chk("t5_to_rise_0", to0, 1'b1);
    chk("t5_to_rise_1", to1, 1'b1);
    tick(3);
    mem = '{ack: 1'b1, r_data: {16{8'h5A}}};
    #3 chk("t5_late_ack", ir0.ack, 1'b1);
    tick(1);
    mem = '0;
    ic = '0;
    tick(1);
    chk("t5_to_sticky", to0, 1'b1);
    // reset mid-BUSY, then a stray ack that must not reach either cache
    ic = '{req: 1'b1, w_en: 1'b0, addr: 32'h500, w_data: '0};
    tick(2);
    #2 rst = 1'b1;
    #1 chk("t6_arb_zero", am0, '0);
    chk("t6_to_clear", to0, 1'b0);
    chk("t6_icache_zero", ir0, '0);
    mem = '{ack: 1'b1, r_data: {16{8'hEE}}};
    ic = '0;
    tick(1);
    rst = 1'b0;
    #3 chk("t6_stray_i", ir0.ack, 1'b0);
    chk("t6_stray_d", dr0.ack, 1'b0);
    chk("t6_idle_req", am0.req, 1'b0);
    tick(1);
    mem = '0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
